// File: rtl/bp_resolve_update_if.sv
// Resolve / PHT / GHR-repair signal bundle for the gshare predictor update block.
// The slave view belongs to the update block, the master view to execute and the PHT RAM.
interface bp_resolve_update_if #(
   parameter int GHR_W     = 14,
   parameter int PHT_IDX_W = 12,
   parameter int CNT_W     = 16
);
   logic                 res_valid;
   logic                 res_ready;
   logic [31:0]          res_pc;
   logic                 res_taken;
   logic                 res_pred_taken;
   logic [GHR_W-1:0]     res_ghr;
   logic                 pht_rd_en;
   logic [PHT_IDX_W-1:0] pht_rd_idx;
   logic [1:0]           pht_rd_data;
   logic                 pht_wr_en;
   logic [PHT_IDX_W-1:0] pht_wr_idx;
   logic [1:0]           pht_wr_data;
   logic                 ghr_repair_valid;
   logic [GHR_W-1:0]     ghr_repair_value;
   logic                 busy;
   logic [CNT_W-1:0]     branch_cnt;
   logic [CNT_W-1:0]     mispred_cnt;

   modport slave (
      input  res_valid, res_pc, res_taken, res_pred_taken, res_ghr, pht_rd_data,
      output res_ready, pht_rd_en, pht_rd_idx, pht_wr_en, pht_wr_idx, pht_wr_data,
             ghr_repair_valid, ghr_repair_value, busy, branch_cnt, mispred_cnt
   );

   modport master (
      output res_valid, res_pc, res_taken, res_pred_taken, res_ghr, pht_rd_data,
      input  res_ready, pht_rd_en, pht_rd_idx, pht_wr_en, pht_wr_idx, pht_wr_data,
             ghr_repair_valid, ghr_repair_value, busy, branch_cnt, mispred_cnt
   );
endinterface

// File: rtl/bp_resolve_update.sv
// gshare update side: buffers resolved branches, does a two-cycle PHT read-modify-write per entry,
// and pulses a speculative-GHR repair on every accepted mispredict.
module bp_resolve_update #(
   parameter int GHR_W      = 14,
   parameter int PHT_IDX_W  = 12,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 16
) (
   input logic                clk,
   input logic                rst,
   bp_resolve_update_if.slave bus
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int OCC_W = PTR_W + 1;
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);
   localparam logic [OCC_W-1:0] OCC_ZERO = OCC_W'(0);
   localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_READ  = 2'd1;
   localparam logic [1:0] ST_WRITE = 2'd2;

   function automatic logic [1:0] sat_inc(input logic [1:0] cnt);
      if (cnt == 2'b11) begin
         return 2'b11;
      end else begin
         return cnt + 2'b01;
      end
   endfunction

   function automatic logic [1:0] sat_dec(input logic [1:0] cnt);
      if (cnt == 2'b00) begin
         return 2'b00;
      end else begin
         return cnt - 2'b01;
      end
   endfunction

   logic [PHT_IDX_W-1:0] idx_mem   [FIFO_DEPTH];
   logic                 taken_mem [FIFO_DEPTH];

   logic [1:0]           state_r;
   logic [PTR_W-1:0]     wr_ptr_r;
   logic [PTR_W-1:0]     rd_ptr_r;
   logic [OCC_W-1:0]     occ_r;
   logic [PHT_IDX_W-1:0] cur_idx_r;
   logic                 cur_taken_r;
   logic                 res_ready_r;
   logic                 busy_r;
   logic                 rd_en_r;
   logic                 wr_en_r;
   logic [PHT_IDX_W-1:0] wr_idx_r;
   logic                 repair_valid_r;
   logic [GHR_W-1:0]     repair_value_r;
   logic [CNT_W-1:0]     branch_cnt_r;
   logic [CNT_W-1:0]     mispred_cnt_r;

   logic                 push_s;
   logic                 pop_s;
   logic                 empty_s;
   logic                 mispred_s;
   logic [PHT_IDX_W-1:0] new_idx_s;
   logic [1:0]           state_s;
   logic [OCC_W-1:0]     occ_s;
   logic [1:0]           wr_data_s;

   // Handshake, FIFO pop decision and mispredict detection.
   always_comb begin
      empty_s   = (occ_r == OCC_ZERO);
      push_s    = bus.res_valid & res_ready_r;
      mispred_s = push_s & (bus.res_taken != bus.res_pred_taken);
      new_idx_s = bus.res_pc[PHT_IDX_W+1:2] ^ bus.res_ghr[PHT_IDX_W-1:0];
      if (((state_r == ST_IDLE) || (state_r == ST_WRITE)) && !empty_s) begin
         pop_s = 1'b1;
      end else begin
         pop_s = 1'b0;
      end
   end

   // Next FSM state and next FIFO occupancy.
   always_comb begin
      state_s = ST_IDLE;
      case (state_r)
         ST_IDLE:  state_s = empty_s ? ST_IDLE : ST_READ;
         ST_READ:  state_s = ST_WRITE;
         ST_WRITE: state_s = empty_s ? ST_IDLE : ST_READ;
         default:  state_s = ST_IDLE;
      endcase
      occ_s = occ_r;
      case ({push_s, pop_s})
         2'b10:   occ_s = occ_r + OCC_ONE;
         2'b01:   occ_s = occ_r - OCC_ONE;
         default: occ_s = occ_r;
      endcase
   end

   // Write data comes straight off the sync RAM output in the WRITE cycle.
   always_comb begin
      if (wr_en_r) begin
         wr_data_s = cur_taken_r ? sat_inc(bus.pht_rd_data) : sat_dec(bus.pht_rd_data);
      end else begin
         wr_data_s = 2'b00;
      end
   end

   // FIFO storage; contents are only meaningful between the pointers.
   always_ff @(posedge clk) begin
      if (push_s) begin
         idx_mem[wr_ptr_r]   <= new_idx_s;
         taken_mem[wr_ptr_r] <= bus.res_taken;
      end
   end

   // FIFO pointers, FSM and registered PHT strobes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= ST_IDLE;
         wr_ptr_r    <= '0;
         rd_ptr_r    <= '0;
         occ_r       <= '0;
         cur_idx_r   <= '0;
         cur_taken_r <= 1'b0;
         rd_en_r     <= 1'b0;
         wr_en_r     <= 1'b0;
         wr_idx_r    <= '0;
         res_ready_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         occ_r       <= occ_s;
         wr_ptr_r    <= push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
         rd_ptr_r    <= pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
         cur_idx_r   <= pop_s ? idx_mem[rd_ptr_r] : cur_idx_r;
         cur_taken_r <= pop_s ? taken_mem[rd_ptr_r] : cur_taken_r;
         rd_en_r     <= (state_s == ST_READ);
         wr_en_r     <= (state_s == ST_WRITE);
         wr_idx_r    <= (state_r == ST_READ) ? cur_idx_r : wr_idx_r;
         res_ready_r <= (occ_s != OCC_FULL);
         busy_r      <= (occ_s != OCC_ZERO) || (state_s != ST_IDLE);
      end
   end

   // GHR repair pulse and saturating statistics.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         repair_valid_r <= 1'b0;
         repair_value_r <= '0;
         branch_cnt_r   <= '0;
         mispred_cnt_r  <= '0;
      end else begin
         repair_valid_r <= mispred_s;
         repair_value_r <= mispred_s ? {bus.res_ghr[GHR_W-2:0], bus.res_taken} : repair_value_r;
         if (push_s && (branch_cnt_r != CNT_MAX)) begin
            branch_cnt_r <= branch_cnt_r + CNT_ONE;
         end else begin
            branch_cnt_r <= branch_cnt_r;
         end
         if (mispred_s && (mispred_cnt_r != CNT_MAX)) begin
            mispred_cnt_r <= mispred_cnt_r + CNT_ONE;
         end else begin
            mispred_cnt_r <= mispred_cnt_r;
         end
      end
   end

   assign bus.res_ready        = res_ready_r;
   assign bus.busy             = busy_r;
   assign bus.pht_rd_en        = rd_en_r;
   assign bus.pht_rd_idx       = cur_idx_r;
   assign bus.pht_wr_en        = wr_en_r;
   assign bus.pht_wr_idx       = wr_idx_r;
   assign bus.pht_wr_data      = wr_data_s;
   assign bus.ghr_repair_valid = repair_valid_r;
   assign bus.ghr_repair_value = repair_value_r;
   assign bus.branch_cnt       = branch_cnt_r;
   assign bus.mispred_cnt      = mispred_cnt_r;
endmodule

// File: tb/tb_bp_resolve_update.sv
// Directed bench for bp_resolve_update: vector table for single updates plus hand sequences
// for back-to-back same-index updates, buffer fill and reset in the middle of a write.
module tb_bp_resolve_update;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   bp_resolve_update_if #(.GHR_W(14), .PHT_IDX_W(12), .CNT_W(16)) bus ();

   bp_resolve_update #(.GHR_W(14), .PHT_IDX_W(12), .FIFO_DEPTH(4), .CNT_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   // PHT RAM model with preload port, plus read/write logging.
   logic [1:0]  pht_mem [4096];
   logic        pre_en = 1'b0;
   logic [11:0] pre_idx = 12'd0;
   logic [1:0]  pre_val = 2'd0;
   logic [13:0] wr_log [$];
   logic [11:0] rd_log [$];
   int          overlap_cnt = 0;

   always @(posedge clk) begin
      if (pre_en) pht_mem[pre_idx] <= pre_val;
      if (bus.pht_rd_en) begin
         bus.pht_rd_data <= pht_mem[bus.pht_rd_idx];
         rd_log.push_back(bus.pht_rd_idx);
      end
      if (bus.pht_wr_en) begin
         pht_mem[bus.pht_wr_idx] <= bus.pht_wr_data;
         wr_log.push_back({bus.pht_wr_idx, bus.pht_wr_data});
      end
      if (bus.pht_rd_en && bus.pht_wr_en) overlap_cnt <= overlap_cnt + 1;
   end

   typedef struct {
      logic [31:0] pc;
      logic [13:0] ghr;
      logic        taken;
      logic        pred;
      logic [1:0]  ram;
      logic [11:0] exp_idx;
      logic [1:0]  exp_data;
      logic        exp_rep;
      logic [13:0] exp_rep_val;
   } vec_t;

   vec_t vecs [7];
   int   wr_seen = 0;
   int   rd_seen = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic preload(input logic [11:0] idx, input logic [1:0] val);
      pre_en = 1'b1; pre_idx = idx; pre_val = val;
      @(posedge clk); #1;
      pre_en = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (bus.busy && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("idle_timeout", {31'd0, bus.busy}, 32'd0);
   endtask

   task automatic wait_writes(input int cnt);
      int n = 0;
      while (wr_log.size() < wr_seen + cnt && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("write_timeout", {31'd0, wr_log.size() >= wr_seen + cnt}, 32'd1);
   endtask

   task automatic drive_res(input logic [31:0] pc, input logic [13:0] ghr,
                            input logic taken, input logic pred);
      bus.res_valid = 1'b1; bus.res_pc = pc; bus.res_ghr = ghr;
      bus.res_taken = taken; bus.res_pred_taken = pred;
   endtask

   logic [13:0] ent;
   int          sent;
   int          first_block;
   logic        ready_s;
   int          wr_snap;

   initial begin
      vecs[0] = '{32'h0000_0010, 14'h0000, 1'b1, 1'b1, 2'd1, 12'h004, 2'd2, 1'b0, 14'h0000};
      vecs[1] = '{32'h0000_0010, 14'h0000, 1'b1, 1'b1, 2'd3, 12'h004, 2'd3, 1'b0, 14'h0000};
      vecs[2] = '{32'h0000_0020, 14'h0000, 1'b0, 1'b0, 2'd0, 12'h008, 2'd0, 1'b0, 14'h0000};
      vecs[3] = '{32'h0000_0000, 14'h0005, 1'b1, 1'b0, 2'd1, 12'h005, 2'd2, 1'b1, 14'h000B};
      vecs[4] = '{32'h0000_4004, 14'h3FFF, 1'b0, 1'b1, 2'd2, 12'hFFE, 2'd1, 1'b1, 14'h3FFE};
      vecs[5] = '{32'h1234_5678, 14'h2ABC, 1'b1, 1'b0, 2'd2, 12'hF22, 2'd3, 1'b1, 14'h1579};
      vecs[6] = '{32'h0000_0008, 14'h0002, 1'b0, 1'b1, 2'd3, 12'h000, 2'd2, 1'b1, 14'h0004};

      bus.res_valid = 1'b0; bus.res_pc = 32'd0; bus.res_ghr = 14'd0;
      bus.res_taken = 1'b0; bus.res_pred_taken = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", {31'd0, bus.res_ready}, 32'd0);
      check("rst_wr_en", {31'd0, bus.pht_wr_en}, 32'd0);
      rst = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("idle_ready", {31'd0, bus.res_ready}, 32'd1);
      check("idle_busy", {31'd0, bus.busy}, 32'd0);
      check("idle_strobes", {30'd0, bus.pht_rd_en, bus.pht_wr_en}, 32'd0);
      check("idle_repair", {31'd0, bus.ghr_repair_valid}, 32'd0);
      check("idle_cnts", {bus.branch_cnt, bus.mispred_cnt}, 32'd0);

      for (int i = 0; i < 7; i++) begin
         wait_idle();
         preload(vecs[i].exp_idx, vecs[i].ram);
         drive_res(vecs[i].pc, vecs[i].ghr, vecs[i].taken, vecs[i].pred);
         @(posedge clk); #1;
         bus.res_valid = 1'b0;
         check($sformatf("v%0d_rep_valid", i), {31'd0, bus.ghr_repair_valid}, {31'd0, vecs[i].exp_rep});
         if (vecs[i].exp_rep)
            check($sformatf("v%0d_rep_value", i), {18'd0, bus.ghr_repair_value}, {18'd0, vecs[i].exp_rep_val});
         @(posedge clk); #1;
         check($sformatf("v%0d_rep_end", i), {31'd0, bus.ghr_repair_valid}, 32'd0);
         wait_writes(1);
         if (wr_log.size() > wr_seen) begin
            ent = wr_log[wr_seen];
            check($sformatf("v%0d_wr_idx", i), {20'd0, ent[13:2]}, {20'd0, vecs[i].exp_idx});
            check($sformatf("v%0d_wr_data", i), {30'd0, ent[1:0]}, {30'd0, vecs[i].exp_data});
            wr_seen++;
         end
         if (rd_log.size() > rd_seen) begin
            check($sformatf("v%0d_rd_idx", i), {20'd0, rd_log[rd_seen]}, {20'd0, vecs[i].exp_idx});
            rd_seen++;
         end
      end
      wait_idle();
      check("branch_cnt", {16'd0, bus.branch_cnt}, 32'd7);
      check("mispred_cnt", {16'd0, bus.mispred_cnt}, 32'd4);

      // Two updates to one index: the second read must see the first write.
      preload(12'h020, 2'd1);
      drive_res(32'h0000_0080, 14'h0000, 1'b1, 1'b1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.res_valid = 1'b0;
      wait_writes(2);
      if (wr_log.size() >= wr_seen + 2) begin
         check("raw_first", {18'd0, wr_log[wr_seen]}, {18'd0, 12'h020, 2'd2});
         check("raw_second", {18'd0, wr_log[wr_seen + 1]}, {18'd0, 12'h020, 2'd3});
         wr_seen += 2;
      end

      // Buffer fill: the drain empties one entry per two cycles, so the fourth
      // entry is only outstanding after seven back-to-back accepts.
      wait_idle();
      for (int k = 0; k < 8; k++) preload(12'(16 + k), 2'd1);
      sent = 0;
      first_block = -1;
      for (int cyc = 0; cyc < 40 && sent < 8; cyc++) begin
         drive_res((32'd16 + 32'(sent)) << 2, 14'h0000, 1'b1, 1'b1);
         ready_s = bus.res_ready;
         if (!ready_s && first_block < 0) first_block = sent;
         @(posedge clk); #1;
         if (ready_s) sent++;
      end
      bus.res_valid = 1'b0;
      check("fill_sent", sent, 32'd8);
      check("fill_block_at", first_block, 32'd7);
      wait_writes(8);
      for (int k = 0; k < 8; k++) begin
         if (wr_log.size() > wr_seen) begin
            check($sformatf("fill_wr%0d", k), {18'd0, wr_log[wr_seen]}, {18'd0, 12'(16 + k), 2'd2});
            wr_seen++;
         end
      end

      // Reset landing in a WRITE cycle drops the update and the queued entries.
      wait_idle();
      for (int k = 0; k < 3; k++) preload(12'(48 + k), 2'd0);
      wr_snap = wr_log.size();
      for (int k = 0; k < 3; k++) begin
         drive_res(32'(48 + k) << 2, 14'h0000, 1'b1, 1'b1);
         @(posedge clk); #1;
      end
      bus.res_valid = 1'b0;
      begin
         int n = 0;
         while (!bus.pht_wr_en && n < 20) begin
            @(posedge clk); #1;
            n++;
         end
         check("wr_seen_before_rst", {31'd0, bus.pht_wr_en}, 32'd1);
      end
      rst = 1'b0;
      #1;
      check("rst_wr_drop", {31'd0, bus.pht_wr_en}, 32'd0);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      @(posedge clk); #2;
      rst = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("rst_no_write", wr_log.size(), wr_snap);
      check("rst_after_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_after_ready", {31'd0, bus.res_ready}, 32'd1);
      check("rst_after_cnt", {16'd0, bus.branch_cnt}, 32'd0);
      check("rd_wr_overlap", overlap_cnt, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
